// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host blocks.
// Holds the host-transmit FSM state enum, common command/response bytes and
// the frame parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_BITS,
    ST_ACK,
    ST_RELEASE,
    ST_DONE
  } ps2_state_e;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  // PS/2 frames use odd parity: data bits plus parity hold an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioner: 2-flop synchronizer, FILT_CYC-sample stability
// filter and falling-edge detector. Shared by host transmitter and receiver.
// Ports:
//   clk, rst   system clock, async active-high reset
//   pin_in     raw pin level
//   level      filtered level (1 after reset)
//   fall       one-cycle pulse in the first cycle level reads 0 after a 1
module ps2_line_filter #(
  parameter int unsigned FILT_CYC = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_in,
  output logic level,
  output logic fall
);

  localparam int unsigned CW = $clog2(FILT_CYC + 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          fall_q, fall_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= pin_in;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      fall_q  <= fall_d;
    end
  end

  // cnt_q counts consecutive samples disagreeing with the accepted level;
  // any agreeing sample restarts the count.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    fall_d  = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(FILT_CYC - 1)) begin
      cnt_d   = '0;
      level_d = sync2_q;
      fall_d  = ~sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign level = level_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Inhibits the bus, issues a start bit, shifts out d0..d7, odd parity and
// stop on device clock falls, then samples the device ACK bit.
// Ports:
//   clk, rst                    system clock, async active-high reset
//   ps2_clk_in, ps2_data_in     raw pin levels
//   ps2_clk_oe, ps2_data_oe     1 = pull line low (open drain)
//   wr_valid, wr_data, wr_ready command byte handshake (ready only in IDLE)
//   busy                        high outside IDLE
//   done, err                   end-of-transfer pulse, err = NACK or timeout
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYC = 2500,
  parameter int unsigned TIMEOUT_CYC = 500000,
  parameter int unsigned FILT_CYC    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned IW = $clog2(INHIBIT_CYC + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  ps2_state_e    state_q, state_d;
  logic [8:0]    frame_q, frame_d;      // {parity, d7..d0}
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [IW-1:0] inh_cnt_q, inh_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          err_q, err_d;

  logic clk_lvl, clk_fall, data_lvl, data_fall_unused;
  logic xfer_active, timeout_hit;

  ps2_line_filter #(.FILT_CYC(FILT_CYC)) u_clk_filt (
    .clk    (clk),
    .rst    (rst),
    .pin_in (ps2_clk_in),
    .level  (clk_lvl),
    .fall   (clk_fall)
  );

  ps2_line_filter #(.FILT_CYC(FILT_CYC)) u_data_filt (
    .clk    (clk),
    .rst    (rst),
    .pin_in (ps2_data_in),
    .level  (data_lvl),
    .fall   (data_fall_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      frame_q   <= '0;
      bit_idx_q <= '0;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_idx_q <= bit_idx_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      err_q     <= err_d;
    end
  end

  assign xfer_active = (state_q == ST_START) || (state_q == ST_BITS) ||
                       (state_q == ST_ACK)   || (state_q == ST_RELEASE);
  // to_cnt_q is 0 in the first START cycle, so DONE lands TIMEOUT_CYC cycles later.
  assign timeout_hit = xfer_active && (to_cnt_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_idx_d = bit_idx_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    err_d     = err_q;
    if (xfer_active) to_cnt_d = to_cnt_q + 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (wr_valid) begin
          frame_d   = {odd_parity(wr_data), wr_data};
          bit_idx_d = '0;
          inh_cnt_d = '0;
          to_cnt_d  = '0;
          err_d     = 1'b0;
          state_d   = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (inh_cnt_q == IW'(INHIBIT_CYC)) state_d = ST_START;
        else                               inh_cnt_d = inh_cnt_q + 1'b1;
      end
      ST_START: begin
        if (clk_fall) begin
          bit_idx_d = '0;
          state_d   = ST_BITS;
        end
      end
      ST_BITS: begin
        // The fall after parity presents stop (line released), which is ACK's drive.
        if (clk_fall) begin
          if (bit_idx_q == 4'd8) state_d = ST_ACK;
          else                   bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      ST_ACK: begin
        if (clk_fall) begin
          err_d   = data_lvl;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (clk_lvl && data_lvl) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (timeout_hit) begin
      err_d   = 1'b1;
      state_d = ST_DONE;
    end
  end

  always_comb begin
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    wr_ready    = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    err         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        wr_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_INHIBIT: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = (inh_cnt_q == IW'(INHIBIT_CYC));
      end
      ST_START:   ps2_data_oe = 1'b1;
      ST_BITS:    ps2_data_oe = ~frame_q[bit_idx_q];
      ST_ACK:     ps2_data_oe = 1'b0;
      ST_RELEASE: ps2_data_oe = 1'b0;
      ST_DONE: begin
        done = 1'b1;
        err  = err_q;
      end
      default: ;
    endcase
  end

endmodule
